seq_mult: RTL
=============

Name: seq_mult

Overview:
- Sequential radix-2 shift-add unsigned multiplier; the inverse operation of the team's repeated-subtraction divider.
- Rebuilds a full-width product from a narrow quotient-sized operand and a wide operand, e.g. step-size × error in the adaptive-filter weight update.
- Start/busy/done handshake, so a controller can chain it directly after the divider.
- One multiplicand bit is processed per clock.

Parameters:
- A_W, 14: multiplicand width. Equals the iteration count. Legal range 2–32.
- B_W, 32: multiplier width. Legal range 2–32.
- Product width is derived as P_W = A_W + B_W. It is a localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- multiplicand  in  A_W  operand a, captured on accepted start.
- multiplier  in  B_W  operand b, captured on accepted start.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; high while state is DONE.
- product  out  P_W  result register; holds its value until the next completion.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE.
  - busy=0, done=0, product=0.
  - All internal registers (a_sh, b_sh, acc, cnt) = 0.
- Reset mid-operation aborts the current multiply immediately. product reads 0 after reset; the aborted result is never produced.
- States and transitions:
  - IDLE: if start=1, load a_sh=multiplicand, b_sh=multiplier (zero-extended to P_W), acc=0, cnt=0, and go to RUN. Otherwise stay in IDLE.
  - RUN, every edge:
    - acc_next = acc + (a_sh[0] ? b_sh : 0).
    - acc <= acc_next; a_sh <= a_sh>>1; b_sh <= b_sh<<1; cnt <= cnt+1.
    - If cnt==A_W-1 (the last iteration), also product <= acc_next and go to DONE.
    - start is ignored in RUN; operands are not re-sampled.
  - DONE: lasts exactly one cycle.
    - If start=1, accept new operands exactly as in IDLE and go to RUN (back-to-back operation).
    - Otherwise go to IDLE.
- Outputs are Moore-decoded from the state registers: busy = (state==RUN), done = (state==DONE).
- Latency: start sampled at edge N → busy high from after edge N to edge N+A_W → done high for the single cycle following edge N+A_W, with product valid in that same cycle.
- Throughput: one result every A_W+1 cycles with start held high.
- Arithmetic:
  - Unsigned throughout.
  - acc and b_sh are P_W wide, so no overflow is possible. Maximum product is (2^A_W−1)(2^B_W−1).
  - cnt is ceil(log2(A_W))+1 bits wide.
- Operand zero: full latency still applies (unless the optional feature below is compiled in); product=0.
- Multiplicand/multiplier may change freely while not being sampled; only the values present at an accepted start matter.

Optional Feature:
- Macro: SEQ_MULT_EARLY_EXIT_EN.
- Defined:
  - In RUN, the block also exits to DONE when (a_sh>>1)==0, i.e. no remaining multiplicand bits are set. product <= acc_next exactly as on a normal final iteration.
  - Latency becomes (index of the highest set bit of a)+1 cycles, with a minimum of 1. a=0 or a=1 completes with done in the cycle after edge N+1.
- Undefined: fixed A_W-cycle latency regardless of operand values.
- Product values are identical in both builds.

Test Plan:
- Reset and basic multiply:
  - Stimulus: reset, then start for one cycle with a=3, b=5 (A_W=14, B_W=32).
  - Response: busy high for 14 cycles, then done=1 for one cycle with product=15; product still 15 ten cycles later.
- Maximum operands:
  - Stimulus: a=16383, b=0xFFFFFFFF.
  - Response: product=0x3FFEFFFFC001 at done; no truncation.
- Start during RUN ignored:
  - Stimulus: start a=2, b=7; pulse start again at cycle 5 with a=9, b=9.
  - Response: a single done at the nominal cycle with product=14; no second done follows.
- Back-to-back:
  - Stimulus: hold start=1; operands a=4, b=10 first, then a=6, b=11 presented during DONE.
  - Response: done pulses 15 cycles apart; products 40 then 66.
- Reset mid-operation:
  - Stimulus: rstn low at RUN cycle 7 of a=100, b=100.
  - Response: busy=0, done=0 and product=0 immediately (asynchronously); a new start a=1, b=1 gives product=1 after full latency.
- Early exit (SEQ_MULT_EARLY_EXIT_EN defined):
  - Stimulus: a=1, b=0x1234; then a=0, b=5; then a=0x2000, b=3.
  - Response: done after 1, 1 and 14 RUN cycles respectively; products 0x1234, 0, 0x6000.
  - With the macro undefined, all three take 14 cycles with the same products.

Source files
------------

// File: rtl/seq_mult.sv
// Sequential radix-2 shift-add unsigned multiplier with start/busy/done handshake.
// Optional build macro SEQ_MULT_EARLY_EXIT_EN ends a run once no multiplicand bits remain.
module seq_mult #(
    parameter int A_W = 14,
    parameter int B_W = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [A_W-1:0]       multiplicand,
    input  logic [B_W-1:0]       multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [A_W+B_W-1:0]   product
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(A_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [A_W-1:0]     r_a_sh;
    logic [P_W-1:0]     r_b_sh;
    logic [P_W-1:0]     r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [P_W-1:0]     r_product;

    logic [P_W-1:0]     w_addend;
    logic [P_W-1:0]     w_acc_next;
    logic               w_last;

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

    // Partial-product add for the current multiplicand bit and end-of-run detection
    always_comb begin
        w_addend   = '0;
        w_last     = 1'b0;
        if (r_a_sh[0]) begin
            w_addend = r_b_sh;
        end else begin
            w_addend = '0;
        end
        w_acc_next = r_acc + w_addend;
        if (r_cnt == CNT_W'(A_W - 1)) begin
            w_last = 1'b1;
        end else begin
            w_last = 1'b0;
        end
`ifdef SEQ_MULT_EARLY_EXIT_EN
        // Nothing left to add once the remaining multiplicand bits are all clear
        if (r_a_sh[A_W-1:1] == '0) begin
            w_last = 1'b1;
        end else begin
            w_last = w_last;
        end
`endif
    end

    // Control FSM, datapath registers and registered Moore outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_a_sh  <= multiplicand;
                        r_b_sh  <= {{A_W{1'b0}}, multiplier};
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_acc  <= w_acc_next;
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh << 1;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_product <= w_acc_next;
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
